// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer
//   Sits between the shape drawers and the framebuffer write port. Each cycle
//   with vga_plot high, it samples one pixel. Off-screen pixels are counted and
//   dropped. On-screen pixels are converted to a linear address and queued in a
//   small FIFO. A single output register then presents them to memory, holding
//   each write steady until mem_ready accepts it.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   vga_x/y/colour/plot pixel strobe from the drawers
//   clear_flags         synchronous clear of overflow and clip_count
//   mem_addr/wdata/we   framebuffer write request, held until accepted
//   mem_ready           memory accepts on a posedge where mem_we && mem_ready
//   busy                FIFO non-empty or a write is pending
//   overflow            sticky: an on-screen pixel arrived while the FIFO was full
//   clip_count          saturating count of discarded off-screen pixels
//
// Output stage states
//   state | meaning
//   EMPTY | output register invalid, mem_we low
//   HOLD  | output register valid, mem_we high until mem_ready
module pixel_write_buffer #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        vga_x,
    input  logic [6:0]        vga_y,
    input  logic [2:0]        vga_colour,
    input  logic              vga_plot,
    input  logic              clear_flags,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        clip_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 3;
    localparam logic [8:0] X_LIM = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ADDR_W-1:0]  x_ext, y_ext, push_addr;
    logic               in_range, want_push, full, push, pop, drop, clip;

    assign x_ext = ADDR_W'(vga_x);
    assign y_ext = ADDR_W'(vga_y);

    // 160 = 128 + 32, so the default screen width needs only two shifts and adds.
    generate
        if (SCREEN_W == 160) begin : g_shift
            assign push_addr = (y_ext << 7) + (y_ext << 5) + x_ext;
        end else begin : g_mul
            assign push_addr = y_ext * ADDR_W'(SCREEN_W) + x_ext;
        end
    endgenerate

    assign in_range  = ({1'b0, vga_x} < X_LIM) && ({1'b0, vga_y} < Y_LIM);
    assign want_push = vga_plot && in_range;
    assign clip      = vga_plot && !in_range;
    assign full      = (count == CNT_W'(DEPTH));
    // A slot freed by a pop on the same edge can take the incoming pixel.
    assign push      = want_push && (!full || pop);
    assign drop      = want_push && full && !pop;

    assign mem_we = (state_q == HOLD);
    assign busy   = (count != '0) || mem_we;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (mem_ready) begin
                    if (count != '0) pop = 1'b1;
                    else             state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                mem_addr  <= fifo_mem[rd_ptr][ENT_W-1:3];
                mem_wdata <= fifo_mem[rd_ptr][2:0];
            end
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {push_addr, vga_colour};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // clear_flags takes priority over a flag event on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            clip_count <= '0;
        end else if (clear_flags) begin
            overflow   <= 1'b0;
            clip_count <= '0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (clip && clip_count != 8'hFF) clip_count <= clip_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_pixel_write_buffer.sv
module tb_pixel_write_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear_flags;
    logic [14:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic        mem_we;
    logic        mem_ready;
    logic        busy;
    logic        overflow;
    logic [7:0]  clip_count;

    int checks = 0;
    int errors = 0;

    pixel_write_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .clear_flags(clear_flags),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .overflow   (overflow),
        .clip_count (clip_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic plot(input int x, input int y, input int c);
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(c);
        vga_plot   = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_we"},    32'(mem_we),     0);
        chk({tag, "_addr"},  32'(mem_addr),   0);
        chk({tag, "_wdata"}, 32'(mem_wdata),  0);
        chk({tag, "_busy"},  32'(busy),       0);
        chk({tag, "_ovf"},   32'(overflow),   0);
        chk({tag, "_clip"},  32'(clip_count), 0);
    endtask

    initial begin
        rst_n = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
        clear_flags = 1'b0; mem_ready = 1'b1;
        #1;
        chk_idle_outputs("reset");
        tick(); tick();
        rst_n = 1'b1;

        // Single pixel: (10,5) -> 5*160+10 = 810, write visible two edges after capture
        plot(10, 5, 5);
        tick();
        vga_plot = 1'b0;
        chk("t1_we_early", 32'(mem_we), 0);
        chk("t1_busy_q",   32'(busy),   1);
        tick();
        chk("t1_we",    32'(mem_we),    1);
        chk("t1_addr",  32'(mem_addr),  810);
        chk("t1_wdata", 32'(mem_wdata), 5);
        tick();
        chk("t1_we_done",   32'(mem_we), 0);
        chk("t1_busy_done", 32'(busy),   0);

        // Full row y=119 at one pixel per cycle: 19040..19199
        for (int k = 0; k < 162; k++) begin
            if (k >= 2) begin
                chk("t2_we",    32'(mem_we),    1);
                chk("t2_addr",  32'(mem_addr),  32'(19040 + k - 2));
                chk("t2_wdata", 32'(mem_wdata), 32'((k - 2) % 8));
            end
            if (k < 160) plot(k, 119, k % 8);
            else         vga_plot = 1'b0;
            tick();
        end
        chk("t2_we_end", 32'(mem_we),   0);
        chk("t2_ovf",    32'(overflow), 0);

        // Stall: 9 pixels fill register + 8 FIFO entries, the 10th overflows
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            plot(i, 1, i % 8);
            tick();
        end
        chk("t3_we",       32'(mem_we),   1);
        chk("t3_head",     32'(mem_addr), 160);
        chk("t3_ovf_none", 32'(overflow), 0);
        plot(9, 1, 1);
        tick();
        vga_plot = 1'b0;
        chk("t3_ovf_set",  32'(overflow), 1);
        chk("t3_head_hold", 32'(mem_addr), 160);
        mem_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            chk("t3_drain_we",   32'(mem_we),    1);
            chk("t3_drain_addr", 32'(mem_addr),  32'(160 + j));
            chk("t3_drain_data", 32'(mem_wdata), 32'(j % 8));
            tick();
        end
        chk("t3_we_end",   32'(mem_we), 0);
        chk("t3_busy_end", 32'(busy),   0);

        // Full FIFO with a pop and a push on the same edge: no loss
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("t6_ovf_cleared", 32'(overflow), 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            plot(i, 2, i % 8);
            tick();
        end
        mem_ready = 1'b1;
        plot(9, 2, 1);
        tick();
        vga_plot = 1'b0;
        chk("t6_ovf", 32'(overflow), 0);
        for (int j = 1; j < 10; j++) begin
            chk("t6_drain_we",   32'(mem_we),   1);
            chk("t6_drain_addr", 32'(mem_addr), 32'(320 + j));
            tick();
        end
        chk("t6_we_end",  32'(mem_we),   0);
        chk("t6_ovf_end", 32'(overflow), 0);

        // Clipping: three off-screen pixels, then saturation, then clear
        plot(160, 0, 1);   tick();
        plot(0, 120, 2);   tick();
        plot(255, 127, 3); tick();
        vga_plot = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_no_we", 32'(mem_we), 0);
            tick();
        end
        chk("t4_clip3", 32'(clip_count), 3);
        for (int i = 0; i < 300; i++) begin
            plot(200, i % 128, 0);
            tick();
        end
        vga_plot = 1'b0;
        chk("t4_clip_sat", 32'(clip_count), 255);
        chk("t4_sat_no_we", 32'(mem_we), 0);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("t4_clip_clr", 32'(clip_count), 0);
        plot(200, 0, 0);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        vga_plot = 1'b0;
        chk("t4_clear_wins", 32'(clip_count), 0);
        plot(200, 0, 0);
        tick();
        vga_plot = 1'b0;
        chk("t4_clip1", 32'(clip_count), 1);

        // Asynchronous reset in the middle of a stalled burst
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            plot(i, 3, 7);
            tick();
        end
        vga_plot = 1'b0;
        tick();
        chk("t5_we_before", 32'(mem_we), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outputs("t5_async");
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_no_stale", 32'(mem_we), 0);
        end
        chk("t5_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
